// File: rtl/csr_access_pipe.sv
// csr_access_pipe: arbitrates one CSR op per cycle across issue lanes, pipes it through DEPTH stages, fault-gates read-valid, keeps sticky fault record and saturating fault count
//   clk_i, rst_ni            clock, async active-low reset
//   opcode_valid_i/set_i/clr_i/fault_i [LANES], rdata_i [LANES*DATA_W]  per-lane request
//   stall_i, flush_i, fault_ack_i      pipeline hold, pipeline kill, fault record consumed
//   replay_o [LANES]         combinational: lane rejected this cycle
//   rd_valid_o, rdata_o, fault_o       registered final-stage result
//   fault_pending_o, fault_lane_o, fault_cnt_o  sticky record and counter
module csr_access_pipe #(
  parameter int LANES  = 2,
  parameter int DEPTH  = 2,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8,
  localparam int LW    = LANES > 1 ? $clog2(LANES) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [LANES-1:0]        opcode_valid_i,
  input  logic [LANES-1:0]        set_i,
  input  logic [LANES-1:0]        clr_i,
  input  logic [LANES-1:0]        fault_i,
  input  logic [LANES*DATA_W-1:0] rdata_i,
  input  logic                    stall_i,
  input  logic                    flush_i,
  input  logic                    fault_ack_i,
  output logic [LANES-1:0]        replay_o,
  output logic                    rd_valid_o,
  output logic [DATA_W-1:0]       rdata_o,
  output logic                    fault_o,
  output logic                    fault_pending_o,
  output logic [LW-1:0]           fault_lane_o,
  output logic [CNT_W-1:0]        fault_cnt_o
);
  localparam int L = DEPTH - 1;
  logic                         any;
  logic [LW-1:0]                sel;
  logic                         retire_flt;
  logic [DEPTH-1:0]             v_q, v_d, rv_q, rv_d, ft_q, ft_d;
  logic [DEPTH-1:0][LW-1:0]     ln_q, ln_d;
  logic [DEPTH-1:0][DATA_W-1:0] dt_q, dt_d;
  logic                         pend_q, pend_d;
  logic [LW-1:0]                flane_q, flane_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  always_comb begin
    any = 1'b0;
    sel = '0;
    for (int k = LANES - 1; k >= 0; k--) begin
      if (opcode_valid_i[k]) begin
        any = 1'b1;
        sel = LW'(k);
      end
    end
  end
  assign replay_o = stall_i ? '0 : opcode_valid_i & ~(LANES'(1) << sel);
  always_comb begin
    v_d  = v_q;
    rv_d = rv_q;
    ft_d = ft_q;
    ln_d = ln_q;
    dt_d = dt_q;
    if (!stall_i) begin
      for (int n = DEPTH - 1; n > 0; n--) begin
        v_d[n]  = v_q[n-1];
        rv_d[n] = rv_q[n-1];
        ft_d[n] = ft_q[n-1];
        ln_d[n] = ln_q[n-1];
        dt_d[n] = dt_q[n-1];
      end
      v_d[0]  = any;
      rv_d[0] = (set_i[sel] | clr_i[sel]) & ~fault_i[sel];
      ft_d[0] = fault_i[sel];
      ln_d[0] = sel;
      dt_d[0] = rdata_i[sel*DATA_W +: DATA_W];
    end
    if (flush_i) v_d = '0;
  end
  assign rd_valid_o      = v_q[L] & rv_q[L];
  assign rdata_o         = rd_valid_o ? dt_q[L] : '0;
  assign fault_o         = v_q[L] & ft_q[L];
  assign fault_pending_o = pend_q;
  assign fault_lane_o    = flane_q;
  assign fault_cnt_o     = cnt_q;
  assign retire_flt      = fault_o & ~stall_i;
  // A retiring fault wins over an ack in the same cycle so it is never lost.
  always_comb begin
    pend_d  = fault_ack_i ? 1'b0 : pend_q;
    flane_d = flane_q;
    if (retire_flt && (!pend_q || fault_ack_i)) begin
      pend_d  = 1'b1;
      flane_d = ln_q[L];
    end
    cnt_d = (retire_flt && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v_q     <= '0;
      rv_q    <= '0;
      ft_q    <= '0;
      ln_q    <= '0;
      dt_q    <= '0;
      pend_q  <= 1'b0;
      flane_q <= '0;
      cnt_q   <= '0;
    end else begin
      v_q     <= v_d;
      rv_q    <= rv_d;
      ft_q    <= ft_d;
      ln_q    <= ln_d;
      dt_q    <= dt_d;
      pend_q  <= pend_d;
      flane_q <= flane_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_csr_access_pipe.sv
// tb_csr_access_pipe: directed table-driven and sequence checks for csr_access_pipe (LANES=2, DEPTH=2, CNT_W=2)
module tb_csr_access_pipe;
  logic        clk, rst_n;
  logic [1:0]  ov, set, clr, flt;
  logic [63:0] rdata;
  logic        stall, flush, ack;
  logic [1:0]  replay;
  logic        rd_valid, fault, pend;
  logic [31:0] rdata_o;
  logic        lane;
  logic [1:0]  cnt;
  int          errors = 0;
  int          checks = 0;

  csr_access_pipe #(.LANES(2), .DEPTH(2), .DATA_W(32), .CNT_W(2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .opcode_valid_i(ov), .set_i(set), .clr_i(clr),
    .fault_i(flt), .rdata_i(rdata), .stall_i(stall), .flush_i(flush), .fault_ack_i(ack),
    .replay_o(replay), .rd_valid_o(rd_valid), .rdata_o(rdata_o), .fault_o(fault),
    .fault_pending_o(pend), .fault_lane_o(lane), .fault_cnt_o(cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  ov, set, clr, flt;
    logic [31:0] d0, d1;
    logic        st, fl, ak;
    logic [1:0]  rep;
    logic        rv;
    logic [31:0] rd;
    logic        fo, pd, ln;
    logic [1:0]  cnt;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [1:0] o, s, c, f, input logic [31:0] d0, d1,
                       input logic st, fl, ak);
    ov = o; set = s; clr = c; flt = f; rdata = {d1, d0};
    stall = st; flush = fl; ack = ak;
  endtask

  task automatic idle();
    drive(2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic rv, input logic [31:0] rd,
                         input logic fo, pd, ln, input logic [1:0] c);
    chk({tag, ".rd_valid"}, 32'(rd_valid), 32'(rv));
    chk({tag, ".rdata"}, rdata_o, rd);
    chk({tag, ".fault"}, 32'(fault), 32'(fo));
    chk({tag, ".pending"}, 32'(pend), 32'(pd));
    chk({tag, ".lane"}, 32'(lane), 32'(ln));
    chk({tag, ".cnt"}, 32'(cnt), 32'(c));
  endtask

  initial begin
    tbl[0]  = '{2'b01, 2'b01, 2'b00, 2'b00, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'd0};
    tbl[1]  = '{2'b01, 2'b00, 2'b01, 2'b01, 32'h12345678, 32'h0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 2'd0};
    tbl[2]  = '{2'b11, 2'b11, 2'b00, 2'b00, 32'hA5A5A5A5, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 2'd0};
    tbl[3]  = '{2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 32'hA5A5A5A5, 1'b0, 1'b1, 1'b0, 2'd1};
    tbl[4]  = '{2'b10, 2'b10, 2'b00, 2'b10, 32'h0, 32'h55555555, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 2'd1};
    tbl[5]  = '{2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 2'd1};
    tbl[6]  = '{2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 2'd2};
    tbl[7]  = '{2'b10, 2'b00, 2'b10, 2'b10, 32'h0, 32'h77777777, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 2'd2};
    tbl[8]  = '{2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 2'd2};
    tbl[9]  = '{2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 2'd3};
    tbl[10] = '{2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 2'd3};
    tbl[11] = '{2'b11, 2'b01, 2'b00, 2'b00, 32'h11111111, 32'h0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 2'd3};

    rst_n = 1'b0;
    idle();
    #2;
    chk_out("reset", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'd0);
    #10 rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].ov, tbl[i].set, tbl[i].clr, tbl[i].flt, tbl[i].d0, tbl[i].d1,
            tbl[i].st, tbl[i].fl, tbl[i].ak);
      #1;
      chk($sformatf("row%0d.replay", i), 32'(replay), 32'(tbl[i].rep));
      tick();
      chk_out($sformatf("row%0d", i), tbl[i].rv, tbl[i].rd, tbl[i].fo, tbl[i].pd, tbl[i].ln, tbl[i].cnt);
    end

    rst_n = 1'b0;
    idle();
    #2 rst_n = 1'b1;
    chk_out("rst2", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'd0);
    for (int i = 0; i < 7; i++) begin
      if (i < 5) drive(2'b01, 2'b00, 2'b01, 2'b01, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      else idle();
      tick();
      if (i >= 1 && i <= 5) chk($sformatf("sat%0d.fault", i), 32'(fault), 32'd1);
      if (i >= 2) chk($sformatf("sat%0d.cnt", i), 32'(cnt), (i - 1 > 3) ? 32'd3 : 32'(i - 1));
    end

    drive(2'b01, 2'b01, 2'b00, 2'b01, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    tick();
    chk("pre_arst.fault", 32'(fault), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_out("arst", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'd0);
    #1 rst_n = 1'b1;

    tick();
    drive(2'b01, 2'b00, 2'b01, 2'b01, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("stall%0d.fault", i), 32'(fault), 32'd0);
    end
    drive(2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("flush.fault", 32'(fault), 32'd0);
    idle();
    tick();
    chk_out("post_flush", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'd0);
    drive(2'b01, 2'b01, 2'b00, 2'b00, 32'h0BADF00D, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    tick();
    chk_out("after_flush_op", 1'b1, 32'h0BADF00D, 1'b0, 1'b0, 1'b0, 2'd0);
    drive(2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    tick();
    chk("hold.rd_valid", 32'(rd_valid), 32'd1);
    chk("hold.rdata", rdata_o, 32'h0BADF00D);
    idle();
    tick();
    chk("drain.rd_valid", 32'(rd_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
